// File: rtl/battle_pkg.sv
// Shared battle datapath constants: default move table, roll scaling, LFSR width, FSM states.
package battle_pkg;
    localparam int LFSR_W    = 4;
    localparam int ACC_SCALE = 10;
    localparam int CRIT_ROLL = 15;

    localparam logic [15:0] DEF_DMG_TABLE = {4'd11, 4'd5, 4'd3, 4'd1};
    localparam logic [15:0] DEF_ACC_TABLE = {4'd3, 4'd7, 4'd8, 4'd10};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/battle_lfsr.sv
// 4-bit Fibonacci LFSR with enable; o_next is the value the register takes when enabled.
module battle_lfsr
    import battle_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 4'b0001
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic [LFSR_W-1:0] o_state,
    output logic [LFSR_W-1:0] o_next
);
    assign o_next = {o_state[LFSR_W-2:0], o_state[LFSR_W-1] ^ o_state[LFSR_W-2]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  o_state <= SEED;
        else if (i_en) o_state <= o_next;
    end
endmodule

// File: rtl/move_resolver.sv
// Sequential move resolver: request handshake, PP bookkeeping, LFSR hit/crit roll,
// registered result handshake. IDLE -> ROLL -> RESP -> IDLE.
module move_resolver
    import battle_pkg::*;
#(
    parameter int                         NUM_MOVES = 4,
    parameter int                         SEL_W     = $clog2(NUM_MOVES),
    parameter int                         DMG_W     = 4,
    parameter logic [NUM_MOVES*DMG_W-1:0] DMG_TABLE = DEF_DMG_TABLE,
    parameter logic [NUM_MOVES*4-1:0]     ACC_TABLE = DEF_ACC_TABLE,
    parameter int                         PP_W      = 3,
    parameter int                         PP_INIT   = 5,
    parameter logic [LFSR_W-1:0]          LFSR_SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] move_sel,
    input  logic             pp_reload,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DMG_W-1:0] res_dmg,
    output logic             res_hit,
    output logic             res_crit,
    output logic             res_no_pp,
    output logic [PP_W-1:0]  pp_left
);
    state_t                            r_state;
    logic [SEL_W-1:0]                  r_sel;
    logic                              r_nopp;
    logic [PP_W-1:0]                   r_pp_after;
    logic [NUM_MOVES-1:0][PP_W-1:0]    r_pp;
    logic [NUM_MOVES-1:0][PP_W-1:0]    w_pp_eff;
    logic [NUM_MOVES-1:0][PP_W-1:0]    w_pp_next;
    logic [PP_W-1:0]                   w_cur;
    logic                              w_accept, w_sel_ok;
    logic [LFSR_W-1:0]                 w_lfsr, w_roll, w_m;
    logic [3:0]                        w_acc;
    logic [DMG_W-1:0]                  w_base, w_dmg;
    logic [DMG_W:0]                    w_dbl;
    logic                              w_hit, w_crit;

    assign req_ready = (r_state == ST_IDLE);
    assign res_valid = (r_state == ST_RESP);
    assign w_accept  = req_valid && req_ready;
    assign w_sel_ok  = int'(move_sel) < NUM_MOVES;

    // Reload applies before the accept's decrement, so a coincident pull ends at PP_INIT-1.
    always_comb begin
        w_pp_eff  = '0;
        w_pp_next = '0;
        w_cur     = '0;
        for (int i = 0; i < NUM_MOVES; i++)
            w_pp_eff[i] = pp_reload ? PP_W'(PP_INIT) : r_pp[i];
        w_pp_next = w_pp_eff;
        if (w_sel_ok) w_cur = w_pp_eff[move_sel];
        if (w_accept && w_cur != '0) w_pp_next[move_sel] = w_cur - PP_W'(1);
    end

    battle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_en    ((r_state == ST_ROLL) && !r_nopp),
        .o_state (w_lfsr),
        .o_next  (w_roll)
    );

    // Roll decode works from values latched at accept, so a reload during ROLL can't leak in.
    always_comb begin
        w_m    = (w_roll >= LFSR_W'(ACC_SCALE)) ? w_roll - LFSR_W'(ACC_SCALE) : w_roll;
        w_acc  = ACC_TABLE[int'(r_sel)*4 +: 4];
        w_base = DMG_TABLE[int'(r_sel)*DMG_W +: DMG_W];
        w_hit  = !r_nopp && (w_m < w_acc);
        w_crit = w_hit && (w_roll == LFSR_W'(CRIT_ROLL));
        w_dbl  = {w_base, 1'b0};
        if (!w_hit)              w_dmg = '0;
        else if (!w_crit)        w_dmg = w_base;
        else if (w_dbl[DMG_W])   w_dmg = '1;
        else                     w_dmg = w_dbl[DMG_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_nopp     <= 1'b0;
            r_pp_after <= '0;
            res_dmg    <= '0;
            res_hit    <= 1'b0;
            res_crit   <= 1'b0;
            res_no_pp  <= 1'b0;
            pp_left    <= '0;
            for (int i = 0; i < NUM_MOVES; i++) r_pp[i] <= PP_W'(PP_INIT);
        end else begin
            r_pp <= w_pp_next;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_sel      <= w_sel_ok ? move_sel : '0;
                    r_nopp     <= (w_cur == '0);
                    r_pp_after <= (w_cur == '0) ? '0 : w_cur - PP_W'(1);
                    r_state    <= ST_ROLL;
                end
                ST_ROLL: begin
                    res_dmg   <= w_dmg;
                    res_hit   <= w_hit;
                    res_crit  <= w_crit;
                    res_no_pp <= r_nopp;
                    pp_left   <= r_pp_after;
                    r_state   <= ST_RESP;
                end
                ST_RESP: if (res_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_resolver.sv
// Directed bench for move_resolver: vector table plus hand-written stall/reset/crit sequences.
module tb_move_resolver;
    logic       clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, res_ready = 1'b1, pp_reload = 1'b0;
    logic [1:0] move_sel = '0;

    logic       b_rq, b_rv, b_hit, b_crit, b_np;
    logic [3:0] b_dmg;
    logic [2:0] b_pp;
    logic       s_rq, s_rv, s_hit, s_crit, s_np;
    logic [3:0] s_dmg;
    logic [2:0] s_pp;
    logic       t_rq, t_rv, t_hit, t_crit, t_np;
    logic [3:0] t_dmg;
    logic [2:0] t_pp;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    move_resolver u_base (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(b_rq), .move_sel(move_sel),
        .pp_reload(pp_reload), .res_valid(b_rv), .res_ready(res_ready), .res_dmg(b_dmg),
        .res_hit(b_hit), .res_crit(b_crit), .res_no_pp(b_np), .pp_left(b_pp));

    move_resolver #(.LFSR_SEED(4'd7)) u_s7 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(s_rq), .move_sel(move_sel),
        .pp_reload(pp_reload), .res_valid(s_rv), .res_ready(res_ready), .res_dmg(s_dmg),
        .res_hit(s_hit), .res_crit(s_crit), .res_no_pp(s_np), .pp_left(s_pp));

    move_resolver #(.LFSR_SEED(4'd7), .DMG_TABLE({4'd11, 4'd5, 4'd3, 4'd12})) u_sat (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(t_rq), .move_sel(move_sel),
        .pp_reload(pp_reload), .res_valid(t_rv), .res_ready(res_ready), .res_dmg(t_dmg),
        .res_hit(t_hit), .res_crit(t_crit), .res_no_pp(t_np), .pp_left(t_pp));

    typedef struct {
        bit rst; int sel; bit rl; bit hit; int dmg; bit crit; bit nopp; int pp;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; req_valid = 1'b0; pp_reload = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Returns at the negedge of the RESP cycle (accept + 2).
    task automatic txn(input int sel, input bit rl);
        @(negedge clk);
        chk("req_ready_idle", b_rq, 1);
        req_valid = 1'b1; move_sel = sel[1:0]; pp_reload = rl;
        @(negedge clk);
        req_valid = 1'b0; pp_reload = 1'b0;
        chk("lat_roll_valid", b_rv, 0);
        chk("lat_roll_ready", b_rq, 0);
        @(negedge clk);
        chk("lat_resp_valid", b_rv, 1);
    endtask

    initial begin
        // seed 1 roll sequence: 2,4,9,3,6,13,...
        vt.push_back('{1, 0, 0, 1, 1, 0, 0, 4});
        vt.push_back('{0, 1, 0, 1, 3, 0, 0, 4});
        vt.push_back('{0, 2, 0, 0, 0, 0, 0, 4});
        vt.push_back('{0, 3, 0, 0, 0, 0, 0, 4});
        vt.push_back('{1, 0, 0, 1, 1, 0, 0, 4});
        vt.push_back('{0, 0, 0, 1, 1, 0, 0, 3});
        vt.push_back('{0, 0, 0, 1, 1, 0, 0, 2});
        vt.push_back('{0, 0, 0, 1, 1, 0, 0, 1});
        vt.push_back('{0, 0, 0, 1, 1, 0, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0, 0, 1, 0});
        vt.push_back('{0, 3, 0, 0, 0, 0, 0, 4});  // roll 13 -> miss; 10 would hit if LFSR had moved
        vt.push_back('{1, 2, 0, 1, 5, 0, 0, 4});
        vt.push_back('{0, 2, 0, 1, 5, 0, 0, 3});
        vt.push_back('{0, 2, 0, 0, 0, 0, 0, 2});
        vt.push_back('{0, 2, 0, 1, 5, 0, 0, 1});
        vt.push_back('{0, 2, 0, 1, 5, 0, 0, 0});
        vt.push_back('{0, 2, 1, 1, 5, 0, 0, 4});  // reload with accept

        repeat (2) @(negedge clk);
        chk("rst_req_ready", b_rq, 1);
        chk("rst_res_valid", b_rv, 0);
        chk("rst_dmg", b_dmg, 0);
        chk("rst_hit", b_hit, 0);
        chk("rst_crit", b_crit, 0);
        chk("rst_no_pp", b_np, 0);
        chk("rst_pp_left", b_pp, 0);
        resetn = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            txn(vt[i].sel, vt[i].rl);
            chk($sformatf("v%0d_hit", i), b_hit, vt[i].hit);
            chk($sformatf("v%0d_dmg", i), b_dmg, vt[i].dmg);
            chk($sformatf("v%0d_crit", i), b_crit, vt[i].crit);
            chk($sformatf("v%0d_nopp", i), b_np, vt[i].nopp);
            chk($sformatf("v%0d_pp", i), b_pp, vt[i].pp);
        end

        // critical rolls: seed 7 gives roll 15
        do_reset();
        txn(1, 0);
        chk("s7_hit", s_hit, 1);
        chk("s7_crit", s_crit, 1);
        chk("s7_dmg", s_dmg, 6);
        do_reset();
        txn(0, 0);
        chk("sat_crit", t_crit, 1);
        chk("sat_dmg", t_dmg, 15);

        // downstream stall with a competing request
        do_reset();
        @(negedge clk);
        res_ready = 1'b0;
        txn(0, 0);
        req_valid = 1'b1; move_sel = 2'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", b_rv, 1);
            chk("stall_ready", b_rq, 0);
            chk("stall_dmg", b_dmg, 1);
            chk("stall_hit", b_hit, 1);
            chk("stall_pp", b_pp, 4);
        end
        req_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", b_rv, 0);
        chk("stall_release_ready", b_rq, 1);
        txn(1, 0);
        chk("post_stall_pp", b_pp, 4);
        chk("post_stall_dmg", b_dmg, 3);

        // reset in ROLL
        do_reset();
        txn(3, 0);
        txn(3, 0);
        @(negedge clk);
        req_valid = 1'b1; move_sel = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("roll_before_rst", b_rv, 0);
        resetn = 1'b0;
        #1;
        chk("rst_in_roll_valid", b_rv, 0);
        chk("rst_in_roll_ready", b_rq, 1);
        @(negedge clk);
        resetn = 1'b1;
        txn(3, 0);
        chk("after_rst_hit", b_hit, 1);
        chk("after_rst_dmg", b_dmg, 11);
        chk("after_rst_pp", b_pp, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
